// File: rtl/svm_pkg.sv
// Shared types and helpers for the linear SVM scorers: FSM state, width
// formulas and the saturate-and-scale step that maps a wide Q sum to DATA_WIDTH.
package svm_pkg;

  typedef enum logic [1:0] {
    IDLE,
    ACC,
    FIN,
    DONE
  } state_t;

  // Widest intermediate the saturate helper accepts.
  localparam int unsigned SAT_W = 128;

  function automatic int unsigned acc_width(input int unsigned dw, input int unsigned nf);
    return 2 * dw + $clog2(nf) + 1;
  endfunction

  function automatic int unsigned class_w(input int unsigned nc);
    return (nc > 1) ? $clog2(nc) : 1;
  endfunction

  function automatic int unsigned addr_w(input int unsigned nc, input int unsigned nf);
    return (nc * (nf + 1) > 1) ? $clog2(nc * (nf + 1)) : 1;
  endfunction

  // Floor-shift by frac, then clamp to the signed dw-bit range.
  function automatic logic signed [SAT_W-1:0] sat_scale(
    input logic signed [SAT_W-1:0] s,
    input int unsigned             frac,
    input int unsigned             dw
  );
    logic signed [SAT_W-1:0] q;
    logic signed [SAT_W-1:0] hi;
    logic signed [SAT_W-1:0] lo;
    q  = s >>> frac;
    hi = $signed((SAT_W'(1) << (dw - 1)) - SAT_W'(1));
    lo = ~hi;
    if (q > hi) return hi;
    else if (q < lo) return lo;
    else return q;
  endfunction

endpackage

// File: rtl/svm_mac_lanes.sv
// LANES signed DATA_WIDTH x DATA_WIDTH multipliers summed into one result.
module svm_mac_lanes #(
  parameter int unsigned DATA_WIDTH = 16,
  parameter int unsigned LANES      = 4
) (
  input  logic [DATA_WIDTH*LANES-1:0]                    a_flat,
  input  logic [DATA_WIDTH*LANES-1:0]                    b_flat,
  output logic signed [2*DATA_WIDTH+$clog2(LANES)-1:0]   sum
);

  localparam int unsigned OUT_W = 2 * DATA_WIDTH + $clog2(LANES);

  logic signed [2*DATA_WIDTH-1:0] prod [LANES];

  always_comb begin
    sum = '0;
    for (int unsigned i = 0; i < LANES; i++) begin
      prod[i] = $signed(a_flat[i*DATA_WIDTH +: DATA_WIDTH]) *
                $signed(b_flat[i*DATA_WIDTH +: DATA_WIDTH]);
      sum     = sum + OUT_W'(prod[i]);
    end
  end

endmodule

// File: rtl/linear_svm_mc.sv
// Multi-class one-vs-rest linear SVM scorer with a time-multiplexed MAC and argmax.
// Optional per-class score output: define LINEAR_SVM_MC_SCORES_EN.
module linear_svm_mc
  import svm_pkg::*;
#(
  parameter int unsigned DATA_WIDTH   = 16,
  parameter int unsigned FRAC_BITS    = 8,
  parameter int unsigned NUM_FEATURES = 20,
  parameter int unsigned NUM_CLASSES  = 4,
  parameter int unsigned LANES        = 4
) (
  input  logic                                        clk,
  input  logic                                        rst,
  input  logic                                        in_valid,
  output logic                                        in_ready,
  input  logic [DATA_WIDTH*NUM_FEATURES-1:0]          features_flat,
  input  logic                                        cfg_we,
  input  logic [addr_w(NUM_CLASSES, NUM_FEATURES)-1:0] cfg_addr,
  input  logic [DATA_WIDTH-1:0]                       cfg_wdata,
  output logic                                        cfg_ready,
  output logic                                        out_valid,
  input  logic                                        out_ready,
  output logic [class_w(NUM_CLASSES)-1:0]             pred_class,
  output logic signed [DATA_WIDTH-1:0]                pred_score
`ifdef LINEAR_SVM_MC_SCORES_EN
  ,
  output logic [DATA_WIDTH*NUM_CLASSES-1:0]           scores_flat
`endif
);

  localparam int unsigned ACC_W   = acc_width(DATA_WIDTH, NUM_FEATURES);
  localparam int unsigned SUM_W   = ACC_W + 1;
  localparam int unsigned CLASS_W = class_w(NUM_CLASSES);
  localparam int unsigned ADDR_W  = addr_w(NUM_CLASSES, NUM_FEATURES);
  localparam int unsigned NCHUNK  = NUM_FEATURES / LANES;
  localparam int unsigned CHUNK_W = (NCHUNK > 1) ? $clog2(NCHUNK) : 1;
  localparam int unsigned FIDX_W  = (NUM_FEATURES > 1) ? $clog2(NUM_FEATURES) : 1;
  localparam int unsigned STRIDE  = NUM_FEATURES + 1;
  localparam int unsigned NREG    = NUM_CLASSES * STRIDE;
  localparam int unsigned MAC_W   = 2 * DATA_WIDTH + $clog2(LANES);

  state_t state, state_nx;

  logic signed [DATA_WIDTH-1:0] feat [NUM_FEATURES];
  logic signed [DATA_WIDTH-1:0] bank [NREG];
  logic [CLASS_W-1:0]           cls;
  logic [CHUNK_W-1:0]           chunk;
  logic signed [ACC_W-1:0]      acc;
  logic [CLASS_W-1:0]           best_class;
  logic signed [DATA_WIDTH-1:0] best_score;

  logic [DATA_WIDTH*LANES-1:0]  a_flat;
  logic [DATA_WIDTH*LANES-1:0]  b_flat;
  logic signed [MAC_W-1:0]      mac;
  logic signed [DATA_WIDTH-1:0] bias;
  logic signed [SUM_W-1:0]      sum;
  logic signed [DATA_WIDTH-1:0] score;
  logic                         last_chunk;
  logic                         last_class;
  logic                         cfg_hit;

  assign last_chunk = (chunk == CHUNK_W'(NCHUNK - 1));
  assign last_class = (cls == CLASS_W'(NUM_CLASSES - 1));
  assign cfg_hit    = cfg_we && cfg_ready && (32'(cfg_addr) < NREG);

  always_comb begin
    a_flat = '0;
    b_flat = '0;
    for (int unsigned i = 0; i < LANES; i++) begin
      a_flat[i*DATA_WIDTH +: DATA_WIDTH] = feat[FIDX_W'(32'(chunk) * LANES + i)];
      b_flat[i*DATA_WIDTH +: DATA_WIDTH] =
        bank[ADDR_W'(32'(cls) * STRIDE + 32'(chunk) * LANES + i)];
    end
  end

  svm_mac_lanes #(
    .DATA_WIDTH(DATA_WIDTH),
    .LANES     (LANES)
  ) u_mac (
    .a_flat(a_flat),
    .b_flat(b_flat),
    .sum   (mac)
  );

  // Bias is aligned to the product scale (2*FRAC_BITS) before the final shift.
  always_comb begin
    bias  = bank[ADDR_W'(32'(cls) * STRIDE + NUM_FEATURES)];
    sum   = SUM_W'(acc) + (SUM_W'(bias) <<< FRAC_BITS);
    score = DATA_WIDTH'(sat_scale(SAT_W'(sum), FRAC_BITS, DATA_WIDTH));
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    unique case (state)
      IDLE: if (in_valid)   state_nx = ACC;
      ACC:  if (last_chunk) state_nx = FIN;
      FIN:  state_nx = last_class ? DONE : ACC;
      DONE: if (out_ready)  state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  always_comb begin
    in_ready  = (state == IDLE);
    cfg_ready = (state == IDLE);
    out_valid = (state == DONE);
  end

  assign pred_class = best_class;
  assign pred_score = best_score;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int unsigned i = 0; i < NUM_FEATURES; i++) feat[i] <= '0;
      for (int unsigned i = 0; i < NREG; i++) bank[i] <= '0;
      cls        <= '0;
      chunk      <= '0;
      acc        <= '0;
      best_class <= '0;
      best_score <= '0;
`ifdef LINEAR_SVM_MC_SCORES_EN
      scores_flat <= '0;
`endif
    end else begin
      unique case (state)
        IDLE: begin
          if (cfg_hit) bank[cfg_addr] <= cfg_wdata;
          if (in_valid) begin
            for (int unsigned i = 0; i < NUM_FEATURES; i++)
              feat[i] <= features_flat[i*DATA_WIDTH +: DATA_WIDTH];
            cls   <= '0;
            chunk <= '0;
            acc   <= '0;
          end
        end
        ACC: begin
          acc   <= acc + ACC_W'(mac);
          chunk <= chunk + CHUNK_W'(1);
        end
        FIN: begin
          if (cls == '0 || score > best_score) begin
            best_score <= score;
            best_class <= cls;
          end
`ifdef LINEAR_SVM_MC_SCORES_EN
          scores_flat[32'(cls)*DATA_WIDTH +: DATA_WIDTH] <= score;
`endif
          if (!last_class) cls <= cls + CLASS_W'(1);
          chunk <= '0;
          acc   <= '0;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_linear_svm_mc.sv
// Scoreboard bench for linear_svm_mc (DW=16, FRAC=8, F=4, L=2, C=3).
module tb_linear_svm_mc;

  localparam int DW  = 16;
  localparam int FB  = 8;
  localparam int NF  = 4;
  localparam int NC  = 3;
  localparam int L   = 2;
  localparam int NR  = NC * (NF + 1);
  localparam int LAT = NC * (NF / L + 1);

  logic               clk = 1'b0;
  logic               rst;
  logic               in_valid;
  logic               in_ready;
  logic [DW*NF-1:0]   features_flat;
  logic               cfg_we;
  logic [3:0]         cfg_addr;
  logic [DW-1:0]      cfg_wdata;
  logic               cfg_ready;
  logic               out_valid;
  logic               out_ready;
  logic [1:0]         pred_class;
  logic signed [DW-1:0] pred_score;
`ifdef LINEAR_SVM_MC_SCORES_EN
  logic [DW*NC-1:0]   scores_flat;
`endif

  logic ready_ctl = 1'b1;
  logic bp_rand   = 1'b1;
  logic rand_bp   = 1'b0;
  assign out_ready = rand_bp ? bp_rand : ready_ctl;

  linear_svm_mc #(
    .DATA_WIDTH  (DW),
    .FRAC_BITS   (FB),
    .NUM_FEATURES(NF),
    .NUM_CLASSES (NC),
    .LANES       (L)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .in_valid     (in_valid),
    .in_ready     (in_ready),
    .features_flat(features_flat),
    .cfg_we       (cfg_we),
    .cfg_addr     (cfg_addr),
    .cfg_wdata    (cfg_wdata),
    .cfg_ready    (cfg_ready),
    .out_valid    (out_valid),
    .out_ready    (out_ready),
    .pred_class   (pred_class),
    .pred_score   (pred_score)
`ifdef LINEAR_SVM_MC_SCORES_EN
    ,
    .scores_flat  (scores_flat)
`endif
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc++;

  always @(posedge clk) begin
    #1;
    bp_rand = ($urandom_range(0, 3) != 0);
  end

  typedef struct {
    int              cls;
    int              score;
    logic [DW*NC-1:0] scores;
    int              acc_cyc;
  } exp_t;

  exp_t sb[$];
  int   wm[NC][NF+1];
  int   fv[NF];
  int   checks = 0;
  int   errors = 0;
  int   hs_cyc = 0;
  int   last_acc = 0;
  logic prev_v = 1'b0;
  exp_t mon_e;

  task automatic chk(input string nm, input longint act, input longint exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d want %0d (t=%0t)", nm, act, exp, $time);
    end
  endtask

  // Reference: plain integer dot products, floor division, clamp, first max wins.
  function automatic exp_t model();
    exp_t   e;
    longint s, q;
    e.cls    = 0;
    e.score  = 0;
    e.scores = '0;
    e.acc_cyc = 0;
    for (int c = 0; c < NC; c++) begin
      s = longint'(wm[c][NF]) * 256;
      for (int i = 0; i < NF; i++) s += longint'(fv[i]) * longint'(wm[c][i]);
      q = s / 256;
      if ((s % 256 != 0) && (s < 0)) q -= 1;
      if (q > 32767)  q = 32767;
      if (q < -32768) q = -32768;
      e.scores[c*DW +: DW] = q[15:0];
      if (c == 0 || q > e.score) begin
        e.cls   = c;
        e.score = int'(q);
      end
    end
    return e;
  endfunction

  always @(negedge clk) begin
    if (rst) begin
      prev_v = 1'b0;
    end else begin
      if (out_valid && !prev_v) begin
        if (sb.size() == 0) chk("unexpected_out_valid", 1, 0);
        else chk("latency", cyc - sb[0].acc_cyc, LAT);
      end
      if (out_valid && out_ready && sb.size() != 0) begin
        mon_e = sb.pop_front();
        chk("pred_class", pred_class, mon_e.cls);
        chk("pred_score", pred_score, mon_e.score);
`ifdef LINEAR_SVM_MC_SCORES_EN
        for (int c = 0; c < NC; c++)
          chk("scores_flat", $signed(scores_flat[c*DW +: DW]), $signed(mon_e.scores[c*DW +: DW]));
`endif
        hs_cyc = cyc + 1;
      end
      prev_v = out_valid;
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic set_feat();
    for (int i = 0; i < NF; i++) features_flat[i*DW +: DW] = fv[i][15:0];
  endtask

  task automatic model_write(input int addr, input int data);
    logic [15:0] d;
    d = data[15:0];
    if (addr < NR) wm[addr / (NF + 1)][addr % (NF + 1)] = int'($signed(d));
  endtask

  task automatic cfg_write(input int addr, input int data);
    cfg_we    = 1'b1;
    cfg_addr  = addr[3:0];
    cfg_wdata = data[15:0];
    step();
    cfg_we = 1'b0;
    model_write(addr, data);
  endtask

  task automatic clear_bank();
    for (int a = 0; a < NR; a++) cfg_write(a, 0);
  endtask

  task automatic run_vec(input bit with_cfg, input int addr, input int data);
    exp_t e;
    int   n;
    set_feat();
    in_valid = 1'b1;
    n = 0;
    while (!in_ready && n < 200) begin
      step();
      n++;
    end
    if (n >= 200) chk("accept_timeout", 0, 1);
    if (with_cfg) begin
      cfg_we    = 1'b1;
      cfg_addr  = addr[3:0];
      cfg_wdata = data[15:0];
      model_write(addr, data);
    end
    e = model();
    step();
    e.acc_cyc = cyc;
    last_acc  = cyc;
    sb.push_back(e);
    in_valid = 1'b0;
    cfg_we   = 1'b0;
    features_flat = {$urandom(), $urandom()};
  endtask

  task automatic wait_drain();
    int n;
    n = 0;
    while (sb.size() != 0 && n < 300) begin
      step();
      n++;
    end
    if (n >= 300) chk("drain_timeout", 0, 1);
  endtask

  task automatic wait_out_valid();
    int n;
    n = 0;
    while (!out_valid && n < 100) begin
      step();
      n++;
    end
    if (n >= 100) chk("out_valid_timeout", 0, 1);
  endtask

  function automatic int rval();
    case ($urandom_range(0, 5))
      0:       return 32767;
      1:       return -32768;
      default: return int'($urandom_range(0, 1200)) - 600;
    endcase
  endfunction

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish, errors %0d", errors);
    $fatal(1);
  end

  initial begin
    int pc, ps;
    rst = 1'b1;
    in_valid = 1'b0;
    features_flat = '0;
    cfg_we = 1'b0;
    cfg_addr = '0;
    cfg_wdata = '0;
    for (int c = 0; c < NC; c++) for (int i = 0; i <= NF; i++) wm[c][i] = 0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_out_valid", out_valid, 0);
    chk("rst_pred_class", pred_class, 0);
    chk("rst_pred_score", pred_score, 0);
    rst = 1'b0;
    step();
    chk("idle_in_ready", in_ready, 1);
    chk("idle_cfg_ready", cfg_ready, 1);

    // Basic argmax
    cfg_write(0, 256);
    cfg_write(6, 256);
    cfg_write(14, -256);
    fv = '{256, 512, 0, 0};
    run_vec(0, 0, 0);
    wait_drain();

    // Tie between classes 0 and 2
    clear_bank();
    cfg_write(0, 256);
    cfg_write(14, 256);
    fv = '{256, 0, 0, 0};
    run_vec(0, 0, 0);
    wait_drain();

    // Positive and negative saturation
    for (int a = 0; a < NR; a++) cfg_write(a, ((a % (NF + 1)) == NF) ? 0 : 32767);
    fv = '{32767, 32767, 32767, 32767};
    run_vec(0, 0, 0);
    wait_drain();
    fv = '{-32768, -32768, -32768, -32768};
    run_vec(0, 0, 0);
    wait_drain();

    // Floor rounding of a small negative result
    clear_bank();
    cfg_write(0, 1);
    cfg_write(9, -512);
    cfg_write(14, -512);
    fv = '{-1, 0, 0, 0};
    run_vec(0, 0, 0);
    wait_drain();

    // Backpressure, config lockout, second vector waiting in DONE
    clear_bank();
    cfg_write(0, 256);
    cfg_write(6, 256);
    cfg_write(14, -256);
    fv = '{256, 512, 0, 0};
    ready_ctl = 1'b0;
    run_vec(0, 0, 0);
    step();
    chk("busy_in_ready", in_ready, 0);
    chk("busy_cfg_ready", cfg_ready, 0);
    cfg_we = 1'b1;
    cfg_addr = 4'd4;
    cfg_wdata = 16'd1000;
    step();
    cfg_we = 1'b0;
    wait_out_valid();
    pc = pred_class;
    ps = pred_score;
    set_feat();
    in_valid = 1'b1;
    repeat (5) begin
      step();
      chk("hold_out_valid", out_valid, 1);
      chk("hold_pred_class", pred_class, pc);
      chk("hold_pred_score", pred_score, ps);
      chk("done_in_ready", in_ready, 0);
    end
    ready_ctl = 1'b1;
    run_vec(0, 0, 0);
    chk("accept_after_handshake", last_acc, hs_cyc + 1);
    wait_drain();

    // Reset during FIN of class 1
    run_vec(0, 0, 0);
    repeat (5) step();
    rst = 1'b1;
    #1;
    chk("midrst_out_valid", out_valid, 0);
    void'(sb.pop_back());
    for (int c = 0; c < NC; c++) for (int i = 0; i <= NF; i++) wm[c][i] = 0;
    @(negedge clk);
    rst = 1'b0;
    step();
    chk("midrst_idle", in_ready, 1);
    chk("midrst_pred_score", pred_score, 0);
    for (int i = 0; i < NF; i++) fv[i] = rval();
    run_vec(0, 0, 0);
    wait_drain();

    // Randomized weights, features, same-cycle writes, invalid addresses, backpressure
    rand_bp = 1'b1;
    for (int k = 0; k < 30; k++) begin
      repeat (4) cfg_write(int'($urandom_range(0, NR - 1)), rval());
      if ($urandom_range(0, 3) == 0) cfg_write(NR, rval());
      for (int i = 0; i < NF; i++) fv[i] = rval();
      run_vec($urandom_range(0, 1) == 1, int'($urandom_range(0, NR)), rval());
      wait_drain();
    end
    rand_bp = 1'b0;

    repeat (3) step();
    chk("scoreboard_empty", sb.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
